// File: rtl/ysyx_22040386_pipe_stage.sv
// rtl/ysyx_22040386_pipe_stage.sv - NPC pipeline stage register with valid/ready, flush/stall and bubble statistics
// Optional skid buffer: define YSYX_22040386_PIPE_SKID_EN.
module ysyx_22040386_pipe_stage #(
    parameter int                 DATA_W = 64 + 32 + 5 + 5,
    parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'('h13),
    parameter int                 CNT_W  = 16
) (
    input  logic              i_PS_clk,
    input  logic              i_PS_rst,
    input  logic              i_PS_flush,
    input  logic              i_PS_stall,
    input  logic              i_PS_valid,
    output logic              o_PS_ready,
    input  logic [DATA_W-1:0] i_PS_data,
    output logic              o_PS_valid,
    input  logic              i_PS_ready,
    output logic [DATA_W-1:0] o_PS_data,
    output logic [1:0]        o_PS_occ,
    output logic [CNT_W-1:0]  o_PS_bubble_cnt
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic              in_fire;
    logic              out_fire;
    logic              cnt_inc;
    logic [CNT_W-1:0]  bubble_cnt;

`ifdef YSYX_22040386_PIPE_SKID_EN
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;

    // Ready depends only on registered skid state, cutting the upstream ready chain.
    assign o_PS_ready = ~i_PS_stall & ~skid_v;
    assign o_PS_occ   = {1'b0, main_v} + {1'b0, skid_v};
`else
    assign o_PS_ready = ~i_PS_stall & (~main_v | i_PS_ready);
    assign o_PS_occ   = {1'b0, main_v};
`endif

    assign o_PS_valid      = main_v & ~i_PS_stall;
    assign in_fire         = i_PS_valid & o_PS_ready;
    assign out_fire        = o_PS_valid & i_PS_ready;
    assign o_PS_data       = main_v ? main_d : BUBBLE;
    // A flush cycle with no valid output still counts once.
    assign cnt_inc         = ~o_PS_valid | i_PS_flush;
    assign o_PS_bubble_cnt = bubble_cnt;

    always_ff @(posedge i_PS_clk) begin
        if (i_PS_rst || i_PS_flush) begin
            main_v <= 1'b0;
            main_d <= BUBBLE;
`ifdef YSYX_22040386_PIPE_SKID_EN
            skid_v <= 1'b0;
            skid_d <= BUBBLE;
`endif
        end else if (!i_PS_stall) begin
`ifdef YSYX_22040386_PIPE_SKID_EN
            if (out_fire && skid_v) begin
                main_d <= skid_d;
                skid_v <= 1'b0;
            end else if (in_fire && main_v && !out_fire) begin
                skid_d <= i_PS_data;
                skid_v <= 1'b1;
            end else if (in_fire) begin
                main_d <= i_PS_data;
                main_v <= 1'b1;
            end else if (out_fire) begin
                main_v <= 1'b0;
            end
`else
            if (in_fire) begin
                main_d <= i_PS_data;
                main_v <= 1'b1;
            end else if (out_fire) begin
                main_v <= 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge i_PS_clk) begin
        if (i_PS_rst) begin
            bubble_cnt <= '0;
        end else if (cnt_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_pipe_stage.sv
// tb/tb_ysyx_22040386_pipe_stage.sv - scoreboard bench for ysyx_22040386_pipe_stage
module tb_ysyx_22040386_pipe_stage;

    localparam int DATA_W = 106;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam logic [DATA_W-1:0] BUB = DATA_W'('h13);
`ifdef YSYX_22040386_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0, flush = 1'b0, stall = 1'b0, valid = 1'b0, ready_in = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              ready_out, valid_out;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        occ;
    logic [CNT_W-1:0]  cnt;
    logic              r2, v2;
    logic [DATA_W-1:0] d2;
    logic [1:0]        occ2;
    logic [3:0]        cnt2;

    always #5 clk = ~clk;

    ysyx_22040386_pipe_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_PS_clk(clk), .i_PS_rst(rst), .i_PS_flush(flush), .i_PS_stall(stall),
        .i_PS_valid(valid), .o_PS_ready(ready_out), .i_PS_data(data),
        .o_PS_valid(valid_out), .i_PS_ready(ready_in), .o_PS_data(data_out),
        .o_PS_occ(occ), .o_PS_bubble_cnt(cnt)
    );

    // Idle instance with a narrow counter for the saturation check.
    ysyx_22040386_pipe_stage #(.DATA_W(DATA_W), .CNT_W(4)) dut_sat (
        .i_PS_clk(clk), .i_PS_rst(rst), .i_PS_flush(1'b0), .i_PS_stall(1'b0),
        .i_PS_valid(1'b0), .o_PS_ready(r2), .i_PS_data('0),
        .o_PS_valid(v2), .i_PS_ready(1'b1), .o_PS_data(d2),
        .o_PS_occ(occ2), .o_PS_bubble_cnt(cnt2)
    );

    // Reference model: the ordered list of held entries plus counter values.
    logic [DATA_W-1:0] q[$];
    int   exp_cnt = 0, exp_cnt2 = 0;
    logic exp_ready = 1'b0;
    logic armed = 1'b0;
    logic p_rst = 1'b0, p_flush = 1'b0, p_in = 1'b0, p_inc = 1'b0;
    logic [DATA_W-1:0] p_data = '0;
    int   passed = 0, total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input logic r, input logic f, input logic s, input logic v,
                       input logic [DATA_W-1:0] d, input logic rd);
        @(posedge clk);
        if (p_rst) begin
            q.delete();
            exp_cnt  = 0;
            exp_cnt2 = 0;
            armed    = 1'b1;
        end else begin
            if (p_flush) q.delete();
            else if (p_in) q.push_back(p_data);
            if (p_inc && exp_cnt != CMAX) exp_cnt++;
            if (exp_cnt2 != 15) exp_cnt2++;
        end
        #1;
        rst = r; flush = f; stall = s; valid = v; data = d; ready_in = rd;
        exp_ready = !s && (SKID ? (q.size() < 2) : (q.size() == 0 || rd));
        p_rst   = r;
        p_flush = f;
        p_in    = v && exp_ready;
        p_data  = d;
        p_inc   = !(q.size() > 0 && !s) || f;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("valid", 128'(valid_out), 128'(q.size() > 0 && !stall));
            check("ready", 128'(ready_out), 128'(exp_ready));
            check("occ", 128'(occ), 128'(q.size()));
            check("bubble_cnt", 128'(cnt), 128'(exp_cnt));
            check("sat_cnt", 128'(cnt2), 128'(exp_cnt2));
            check("data", 128'(data_out), 128'((q.size() > 0) ? q[0] : BUB));
            if (valid_out && ready_in) begin
                if (q.size() > 0) void'(q.pop_front());
                else check("unexpected_beat", 128'(data_out), 128'(BUB) ^ 128'(1));
            end
        end
    end

    initial begin
        logic [127:0] r128;
        int nb, guard;
        // Reset with a valid beat offered
        cyc(1, 0, 0, 1, DATA_W'('hAB), 1);
        cyc(1, 0, 0, 1, DATA_W'('hAB), 1);
        // Streaming
        for (int i = 1; i <= 8; i++) cyc(0, 0, 0, 1, DATA_W'(i), 1);
        cyc(0, 0, 0, 0, '0, 1);
        cyc(0, 0, 0, 0, '0, 1);
        // Backpressure after beat 5
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, DATA_W'(i), 1);
        nb = 6;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, DATA_W'(nb), 0);
            if (p_in) nb++;
        end
        guard = 0;
        while (nb <= 7 && guard < 10) begin
            cyc(0, 0, 0, 1, DATA_W'(nb), 1);
            if (p_in) nb++;
            guard++;
        end
        check("bp_progress", 128'(nb), 128'(8));
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, '0, 1);
        // Stall while holding 0x40
        cyc(0, 0, 0, 1, DATA_W'('h40), 0);
        cyc(0, 0, 1, 0, '0, 1);
        cyc(0, 0, 1, 0, '0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, '0, 1);
        // Flush with stall and a full stage
        cyc(0, 0, 0, 1, DATA_W'('h51), 0);
        cyc(0, 0, 0, 1, DATA_W'('h52), 0);
        cyc(0, 1, 1, 1, DATA_W'('h53), 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, '0, 1);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc(($urandom_range(99) < 1), ($urandom_range(99) < 3), ($urandom_range(99) < 10),
                ($urandom_range(99) < 70), r128[DATA_W-1:0], ($urandom_range(99) < 60));
        end
        // Idle long enough to saturate the narrow counter
        cyc(1, 0, 0, 0, '0, 1);
        for (int i = 0; i < 22; i++) cyc(0, 0, 0, 0, '0, 1);
        @(negedge clk);
        #1;
        check("sat_final", 128'(cnt2), 128'(15));
        check("drained", 128'(q.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
